// File: rtl/mmcm_drp_sequencer.sv
// -----------------------------------------------------------------------------
// mmcm_drp_sequencer
//
// Applies a sequence of read-modify-write updates to the MMCME2_ADV dynamic
// reconfiguration port. The MMCM is held in reset while its registers are
// being rewritten, then released, and the sequencer waits for lock before
// reporting completion.
//
// Ports
//   clk, resetN                system clock (also DCLK), synchronous active-low reset
//   cfgValid/cfgReady          entry handshake from the host
//   cfgAddr/cfgMask/cfgData    DRP address, keep-mask (1 = keep old bit), new bits
//   cfgLast                    marks the final entry of a sequence
//   drpAddr/drpEn/drpWe/drpDi  to MMCM DADDR/DEN/DWE/DI
//   drpDo/drpRdy               from MMCM DO/DRDY
//   mmcmRst/mmcmLocked         MMCM RST out, LOCKED in
//   busy, done, error          sequence status (done is a one-cycle pulse,
//                              error is sticky until the next sequence starts)
//   isLocked                   registered LOCKED, only reported while idle
// -----------------------------------------------------------------------------
module mmcm_drp_sequencer #(
    parameter int RST_HOLD     = 8,
    parameter int DRP_TIMEOUT  = 64,
    parameter int LOCK_TIMEOUT = 65536
) (
    input  logic        clk,
    input  logic        resetN,
    input  logic        cfgValid,
    output logic        cfgReady,
    input  logic [6:0]  cfgAddr,
    input  logic [15:0] cfgMask,
    input  logic [15:0] cfgData,
    input  logic        cfgLast,
    output logic [6:0]  drpAddr,
    output logic        drpEn,
    output logic        drpWe,
    output logic [15:0] drpDi,
    input  logic [15:0] drpDo,
    input  logic        drpRdy,
    output logic        mmcmRst,
    input  logic        mmcmLocked,
    output logic        busy,
    output logic        done,
    output logic        error,
    output logic        isLocked
);

    localparam int MAX_AB = (RST_HOLD > DRP_TIMEOUT) ? RST_HOLD : DRP_TIMEOUT;
    localparam int MAX_P  = (MAX_AB > LOCK_TIMEOUT) ? MAX_AB : LOCK_TIMEOUT;
    localparam int CNT_W  = $clog2(MAX_P) + 1;

    localparam logic [CNT_W-1:0] CNT_MAX   = '1;
    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(RST_HOLD - 1);
    localparam logic [CNT_W-1:0] DRP_LAST  = CNT_W'(DRP_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] LOCK_LAST = CNT_W'(LOCK_TIMEOUT - 1);

    localparam logic [3:0] S_IDLE      = 4'd0;
    localparam logic [3:0] S_HOLD      = 4'd1;
    localparam logic [3:0] S_READ      = 4'd2;
    localparam logic [3:0] S_WAIT_RD   = 4'd3;
    localparam logic [3:0] S_WRITE     = 4'd4;
    localparam logic [3:0] S_WAIT_WR   = 4'd5;
    localparam logic [3:0] S_NEXT      = 4'd6;
    localparam logic [3:0] S_RELEASE   = 4'd7;
    localparam logic [3:0] S_WAIT_LOCK = 4'd8;

    logic [3:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [6:0]       addr_q, addr_d;
    logic [15:0]      mask_q, mask_d;
    logic [15:0]      data_q, data_d;
    logic             last_q, last_d;
    logic [15:0]      drp_di_q, drp_di_d;
    logic             cfg_ready_q, cfg_ready_d;
    logic             drp_en_q, drp_en_d;
    logic             drp_we_q, drp_we_d;
    logic             mmcm_rst_q, mmcm_rst_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             error_q, error_d;
    logic             locked_q, locked_d;
    logic             is_locked_q, is_locked_d;

    logic             accept;
    logic [CNT_W-1:0] cnt_inc;

    // cfg_ready_q is itself a registered output, so a handshake is exactly
    // what the host sees: valid while the registered ready is high.
    assign accept  = cfgValid && cfg_ready_q;
    // Saturating increment: the counter never wraps back to zero.
    assign cnt_inc = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1;

    always_comb begin
        // NOTE: every signal assigned here gets a default first; a path that
        // leaves one unassigned would infer a latch.
        state_d  = state_q;
        cnt_d    = cnt_inc;
        addr_d   = addr_q;
        mask_d   = mask_q;
        data_d   = data_q;
        last_d   = last_q;
        drp_di_d = drp_di_q;
        error_d  = error_q;
        done_d   = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    addr_d  = cfgAddr;
                    mask_d  = cfgMask;
                    data_d  = cfgData;
                    last_d  = cfgLast;
                    error_d = 1'b0;
                    cnt_d   = '0;
                    state_d = S_HOLD;
                end
            end
            S_HOLD: begin
                if (cnt_q == HOLD_LAST) state_d = S_READ;
            end
            S_READ: begin
                cnt_d   = '0;
                state_d = S_WAIT_RD;
            end
            S_WAIT_RD: begin
                if (drpRdy) begin
                    drp_di_d = (drpDo & mask_q) | (data_q & ~mask_q);
                    state_d  = S_WRITE;
                end else if (cnt_q == DRP_LAST) begin
                    error_d = 1'b1;
                    state_d = S_RELEASE;
                end
            end
            S_WRITE: begin
                cnt_d   = '0;
                state_d = S_WAIT_WR;
            end
            S_WAIT_WR: begin
                if (drpRdy) begin
                    state_d = last_q ? S_RELEASE : S_NEXT;
                end else if (cnt_q == DRP_LAST) begin
                    error_d = 1'b1;
                    state_d = S_RELEASE;
                end
            end
            S_NEXT: begin
                if (accept) begin
                    addr_d  = cfgAddr;
                    mask_d  = cfgMask;
                    data_d  = cfgData;
                    last_d  = cfgLast;
                    state_d = S_READ;
                end
            end
            S_RELEASE: begin
                cnt_d   = '0;
                state_d = S_WAIT_LOCK;
            end
            S_WAIT_LOCK: begin
                if (mmcmLocked) begin
                    done_d  = 1'b1;
                    state_d = S_IDLE;
                end else if (cnt_q == LOCK_LAST) begin
                    error_d = 1'b1;
                    done_d  = 1'b1;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Outputs are decoded from the next state so that each registered
        // output is valid in the very cycle the FSM occupies that state.
        cfg_ready_d = (state_d == S_IDLE) || (state_d == S_NEXT);
        drp_en_d    = (state_d == S_READ) || (state_d == S_WRITE);
        drp_we_d    = (state_d == S_WRITE);
        busy_d      = (state_d != S_IDLE);
        // RST stays high through RELEASE and falls on entry to WAIT_LOCK.
        mmcm_rst_d  = (state_d != S_IDLE) && (state_d != S_WAIT_LOCK);
        locked_d    = mmcmLocked;
        is_locked_d = locked_q && (state_d == S_IDLE);
    end

    always_ff @(posedge clk) begin
        // NOTE: reset is sampled on the clock edge only (synchronous), and all
        // state updates use non-blocking assignments so every flop sees the
        // pre-edge values of the others.
        if (!resetN) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            addr_q      <= '0;
            mask_q      <= '0;
            data_q      <= '0;
            last_q      <= 1'b0;
            drp_di_q    <= '0;
            cfg_ready_q <= 1'b0;
            drp_en_q    <= 1'b0;
            drp_we_q    <= 1'b0;
            mmcm_rst_q  <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            error_q     <= 1'b0;
            locked_q    <= 1'b0;
            is_locked_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            addr_q      <= addr_d;
            mask_q      <= mask_d;
            data_q      <= data_d;
            last_q      <= last_d;
            drp_di_q    <= drp_di_d;
            cfg_ready_q <= cfg_ready_d;
            drp_en_q    <= drp_en_d;
            drp_we_q    <= drp_we_d;
            mmcm_rst_q  <= mmcm_rst_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            error_q     <= error_d;
            locked_q    <= locked_d;
            is_locked_q <= is_locked_d;
        end
    end

    assign cfgReady = cfg_ready_q;
    assign drpAddr  = addr_q;
    assign drpEn    = drp_en_q;
    assign drpWe    = drp_we_q;
    assign drpDi    = drp_di_q;
    assign mmcmRst  = mmcm_rst_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign error    = error_q;
    assign isLocked = is_locked_q;

endmodule
